sys_cmd_ctrl: RTL and testbench
===============================

Name: sys_cmd_ctrl

Overview:
- Command controller between the UART receiver/transmitter, the register file and the ALU (arithmetic/logic units).
- Parses byte-wide command frames from RX and sequences register-file writes/reads and ALU operations.
- Returns results to the TX path through a valid/busy handshake.
- Sole master of the ALU enable/function lines and the register-file port.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes, operands and RF data
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width
TIMEOUT_CYCLES, 1024, idle-cycle limit (used only with CMD_TIMEOUT_EN)

Ports:
CLK  in  1  system clock
RST  in  1  reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe: RX_P_DATA valid
RF_WR_EN  out  1  RF write strobe
RF_RD_EN  out  1  RF read strobe
RF_ADDR  out  ADDR_WIDTH  RF address
RF_WR_DATA  out  DATA_WIDTH  RF write data
RF_RD_DATA  in  DATA_WIDTH  RF read data
RF_RD_VLD  in  1  RF read data valid
ALU_EN  out  1  ALU enable strobe
ALU_FUN  out  FUN_WIDTH  ALU function select
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  one-cycle strobe: TX_P_DATA valid
TX_BUSY  in  1  transmitter busy

Interface: one clock; reset is asynchronous and active-high. Clock port is CLK, reset port is RST.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE; every output 0; internal result/address registers 0.
- Command codes:
  - 0xAA: RF write, frame {AA, addr, data}
  - 0xBB: RF read, frame {BB, addr}
  - 0xCC: ALU with operands, frame {CC, A, B, fun}
  - 0xDD: ALU without operands, frame {DD, fun}
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_GAP, TX_HI.
- IDLE: on RX_D_VLD, a matching code moves to WR_ADDR / RD_ADDR / OP_A / ALU_FUN respectively. Any other byte is discarded and the state stays IDLE.
- WR_ADDR: latch addr[ADDR_WIDTH-1:0] (upper bits ignored), go to WR_DATA.
- WR_DATA: on byte, RF_WR_EN=1 for exactly one cycle with the latched address and the data byte; go to IDLE. No TX response.
- RD_ADDR: on byte, RF_RD_EN=1 for one cycle with RF_ADDR=addr; go to RD_WAIT.
- RD_WAIT: on RF_RD_VLD, capture RF_RD_DATA as low byte, mark 1-byte response; go to TX_LO.
- OP_A: on byte, RF write to address 0; go to OP_B.
- OP_B: on byte, RF write to address 1; go to ALU_FUN.
- ALU_FUN: on byte, ALU_EN=1 for one cycle with ALU_FUN=byte[FUN_WIDTH-1:0]; go to ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT, mark 2-byte response; go to TX_LO.
- CLK_GATE_EN: 1 in OP_A, OP_B, ALU_FUN and ALU_WAIT; 0 elsewhere.
- TX_LO: when TX_BUSY=0, TX_D_VLD=1 for one cycle with the low byte.
  - 1-byte response: go to IDLE.
  - 2-byte response: go to TX_GAP.
- TX_GAP: unconditional single cycle, lets TX_BUSY rise; go to TX_HI.
- TX_HI: when TX_BUSY=0, TX_D_VLD=1 for one cycle with the high byte; go to IDLE.
- ALU_FUN and RF_ADDR hold their last values between strobes.
- RX_D_VLD in RD_WAIT, ALU_WAIT or any TX state: byte silently dropped, no state change.
- RF_RD_VLD / ALU_OUT_VLD outside their wait states: ignored.
- RST asserted mid-frame or mid-transmit: immediate return to IDLE; any partial frame is lost.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A counter clears on every state change and on RX_D_VLD.
  - It increments in every non-IDLE state except the TX states.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE; no strobes are issued on abort.
- Undefined: no counter; the FSM waits indefinitely for bytes and valids.

Decomposition:
- Shared package: command code constants (AA/BB/CC/DD), state encoding, operand RF addresses (0, 1).
- Sub-module: sys_cmd_timeout, the idle counter (instantiated only under CMD_TIMEOUT_EN).

Test Plan:
- {AA,05,3C} -> single RF_WR_EN pulse with addr 5, data 0x3C; no TX_D_VLD.
- {BB,05}, RF returns 0x3C two cycles later -> one TX_D_VLD with 0x3C, then IDLE.
- {CC,0A,03,00}, ALU_OUT=0x000D -> RF writes addr0=0x0A and addr1=0x03, ALU_EN with fun 0. TX then sends 0x0D followed by 0x00; the second byte comes ≥2 cycles after the first, and each is issued only while TX_BUSY=0.
- {DD,02}, with TX_BUSY held high 20 cycles after ALU_OUT_VLD -> TX_D_VLD withheld until TX_BUSY falls; no duplicate bytes.
- Byte 0x55 in IDLE, and RX bytes during ALU_WAIT -> ignored; the next {AA,..} frame executes normally.
- RST pulse between OP_A and OP_B -> all outputs 0, IDLE. With CMD_TIMEOUT_EN, frame {CC,0A} followed by silence -> IDLE after TIMEOUT_CYCLES, with no ALU_EN.

Source files
------------

// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the command controller: frame command codes,
// FSM state encoding and the fixed RF addresses used for ALU operands.
package sys_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_GAP,
        S_TX_HI
    } state_e;

    function automatic logic is_tx_state(input state_e s);
        return (s == S_TX_LO) || (s == S_TX_GAP) || (s == S_TX_HI);
    endfunction

    // The ALU clock runs from the first operand byte until its result is back.
    function automatic logic is_alu_state(input state_e s);
        return (s == S_OP_A) || (s == S_OP_B) || (s == S_ALU_FUN) || (s == S_ALU_WAIT);
    endfunction

endpackage

// File: rtl/sys_cmd_timeout.sv
// Idle counter: flags expiry after TIMEOUT_CYCLES cycles without a byte or
// state change while the controller is inside a frame.
module sys_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (run_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command controller: parses RX frames, drives RF/ALU strobes and returns
// results to TX. Optional idle abort is enabled by defining CMD_TIMEOUT_EN.
module sys_cmd_ctrl
    import sys_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_VLD,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_BUSY
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic                    two_byte_q, two_byte_d;
    logic                    rf_wr_en_q, rf_wr_en_d;
    logic                    rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
    logic                    alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    tmo_expired;

`ifdef CMD_TIMEOUT_EN
    logic tmo_clr, tmo_run;

    assign tmo_run = (state_q != S_IDLE) && !is_tx_state(state_q);
    assign tmo_clr = (state_d != state_q) || RX_D_VLD;

    sys_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (tmo_clr),
        .run_i     (tmo_run),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        res_d        = res_q;
        two_byte_d   = two_byte_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = 1'b0;
        alu_fun_d    = alu_fun_q;
        tx_data_d    = tx_data_q;
        tx_vld_d     = 1'b0;

        // An abort only moves the FSM; every strobe stays low and held values are kept.
        if (tmo_expired) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))        state_d = S_WR_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))   state_d = S_RD_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = S_OP_A;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = S_ALU_FUN;
                end
                S_WR_ADDR: if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = S_WR_DATA;
                end
                S_WR_DATA: if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = addr_q;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = S_IDLE;
                end
                S_RD_ADDR: if (RX_D_VLD) begin
                    addr_d     = RX_P_DATA[ADDR_WIDTH-1:0];
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d    = S_RD_WAIT;
                end
                S_RD_WAIT: if (RF_RD_VLD) begin
                    res_d      = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                    two_byte_d = 1'b0;
                    state_d    = S_TX_LO;
                end
                S_OP_A: if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = S_OP_B;
                end
                S_OP_B: if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = S_ALU_FUN;
                end
                S_ALU_FUN: if (RX_D_VLD) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                    state_d   = S_ALU_WAIT;
                end
                S_ALU_WAIT: if (ALU_OUT_VLD) begin
                    res_d      = ALU_OUT;
                    two_byte_d = 1'b1;
                    state_d    = S_TX_LO;
                end
                S_TX_LO: if (!TX_BUSY) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = res_q[DATA_WIDTH-1:0];
                    state_d   = two_byte_q ? S_TX_GAP : S_IDLE;
                end
                // One dead cycle so the transmitter can raise TX_BUSY for the first byte.
                S_TX_GAP: state_d = S_TX_HI;
                S_TX_HI: if (!TX_BUSY) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            res_q        <= '0;
            two_byte_q   <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            tx_data_q    <= '0;
            tx_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            res_q        <= res_d;
            two_byte_q   <= two_byte_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            tx_data_q    <= tx_data_d;
            tx_vld_q     <= tx_vld_d;
        end
    end

    assign RF_WR_EN    = rf_wr_en_q;
    assign RF_RD_EN    = rf_rd_en_q;
    assign RF_ADDR     = rf_addr_q;
    assign RF_WR_DATA  = rf_wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;
    assign CLK_GATE_EN = is_alu_state(state_q);

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: RF/ALU/TX stand-ins plus a frame-level
// reference model; timeout scenario runs when CMD_TIMEOUT_EN is defined.
module tb_sys_cmd_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int FW  = 4;
    localparam int TMO = 1024;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic          RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    logic [AW-1:0] RF_ADDR;
    logic [DW-1:0] RF_WR_DATA, TX_P_DATA;
    logic [DW-1:0] RF_RD_DATA = '0;
    logic          RF_RD_VLD = 1'b0;
    logic [FW-1:0] ALU_FUN;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic          ALU_OUT_VLD = 1'b0;
    logic          TX_BUSY;
    logic          force_busy = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // Environment state (written only by the monitor process)
    int cyc = 0;
    int rd_pend = 0;
    int alu_pend = 0;
    int busy_cnt = 0;
    int busy_viol = 0;
    int alu_vld_cnt = 0;
    logic [AW-1:0]   rd_addr = '0;
    logic [2*DW-1:0] alu_res_pend = '0;
    logic [DW-1:0]   rf_mem [16] = '{default: '0};
    logic [11:0]     obs_wr[$];
    logic [AW-1:0]   obs_rd[$];
    logic [FW-1:0]   obs_alu[$];
    logic [DW-1:0]   obs_tx[$];
    int              obs_tx_cyc[$];
    logic            busy_seen = 1'b0;

    // Stimulus-side state
    int              alu_lat = 3;
    int              busy_len = 3;
    logic [DW-1:0]   ref_rf [16] = '{default: '0};

    assign TX_BUSY = force_busy | (busy_cnt != 0);

    sys_cmd_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR),
        .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a} * {8'h00, b};
            4'd3:    return {8'h00, a & b};
            default: return {a, b} ^ 16'hA5C3;
        endcase
    endfunction

    always @(posedge CLK) busy_seen <= TX_BUSY;

    // Monitor and RF / ALU / TX stand-ins, all acting away from the active edge
    always @(negedge CLK) begin
        cyc = cyc + 1;
        RF_RD_VLD = 1'b0;
        ALU_OUT_VLD = 1'b0;
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (rd_pend > 0) begin
            rd_pend = rd_pend - 1;
            if (rd_pend == 0) begin
                RF_RD_VLD = 1'b1;
                RF_RD_DATA = rf_mem[rd_addr];
            end
        end
        if (alu_pend > 0) begin
            alu_pend = alu_pend - 1;
            if (alu_pend == 0) begin
                ALU_OUT_VLD = 1'b1;
                ALU_OUT = alu_res_pend;
                alu_vld_cnt = alu_vld_cnt + 1;
            end
        end
        if (RF_WR_EN) begin
            obs_wr.push_back({RF_ADDR, RF_WR_DATA});
            rf_mem[RF_ADDR] = RF_WR_DATA;
        end
        if (RF_RD_EN) begin
            obs_rd.push_back(RF_ADDR);
            rd_pend = 2;
            rd_addr = RF_ADDR;
        end
        if (ALU_EN) begin
            obs_alu.push_back(ALU_FUN);
            alu_pend = alu_lat;
            alu_res_pend = alu_fn(rf_mem[0], rf_mem[1], ALU_FUN);
        end
        if (TX_D_VLD) begin
            obs_tx.push_back(TX_P_DATA);
            obs_tx_cyc.push_back(cyc);
            if (busy_seen) busy_viol = busy_viol + 1;
            busy_cnt = busy_len;
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD = 1'b1;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
    endtask

    task automatic wait_tx(input int base, input int n, input int limit, output bit ok);
        int k = 0;
        while ((obs_tx.size() - base) < n && k < limit) begin
            @(negedge CLK);
            k++;
        end
        ok = (obs_tx.size() - base) >= n;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        settle(2);
        n_chk++;
        if ({RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CLK_GATE_EN} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000", {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CLK_GATE_EN});
        end
        n_chk++;
        if ({RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA});
        end
        RST = 1'b0;
        settle(2);
    endtask

    task automatic test_write(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a, d;
            int wb, ob;
            a = (i == 0) ? 8'h05 : 8'($urandom);
            d = (i == 0) ? 8'h3C : 8'($urandom);
            wb = obs_wr.size();
            ob = obs_tx.size() + obs_alu.size() + obs_rd.size();
            send_byte(8'hAA); send_byte(a); send_byte(d);
            settle(4);
            n_chk++;
            if (obs_wr.size() - wb !== 1) begin
                n_fail++;
                $display("FAIL wr_count: got %0d want 1", obs_wr.size() - wb);
            end else begin
                n_chk++;
                if (obs_wr[wb] !== {a[3:0], d}) begin
                    n_fail++;
                    $display("FAIL wr_data: got %h want %h", obs_wr[wb], {a[3:0], d});
                end
            end
            n_chk++;
            if (obs_tx.size() + obs_alu.size() + obs_rd.size() - ob !== 0) begin
                n_fail++;
                $display("FAIL wr_side_effects: got %0d extra events want 0", obs_tx.size() + obs_alu.size() + obs_rd.size() - ob);
            end
            n_chk++;
            if (RF_ADDR !== a[3:0]) begin
                n_fail++;
                $display("FAIL wr_addr_hold: got %h want %h", RF_ADDR, a[3:0]);
            end
            ref_rf[a[3:0]] = d;
        end
    endtask

    task automatic test_read(input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] a;
            int tb, rb;
            bit ok;
            a = (i == 0) ? 4'h5 : 4'($urandom);
            tb = obs_tx.size();
            rb = obs_rd.size();
            send_byte(8'hBB); send_byte({4'($urandom), a});
            wait_tx(tb, 1, 30, ok);
            settle(5);
            n_chk++;
            if (!ok || obs_tx.size() - tb !== 1 || obs_rd.size() - rb !== 1) begin
                n_fail++;
                $display("FAIL rd_count: got tx=%0d rd=%0d want 1 1", obs_tx.size() - tb, obs_rd.size() - rb);
            end else begin
                n_chk++;
                if (obs_rd[rb] !== a) begin
                    n_fail++;
                    $display("FAIL rd_addr: got %h want %h", obs_rd[rb], a);
                end
                n_chk++;
                if (obs_tx[tb] !== ref_rf[a]) begin
                    n_fail++;
                    $display("FAIL rd_tx_byte: got %h want %h", obs_tx[tb], ref_rf[a]);
                end
            end
        end
    endtask

    task automatic test_alu_op(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a, b, fb;
            logic [15:0] exp;
            int wb, ab, tb, vb;
            bit ok;
            a  = (i == 0) ? 8'h0A : 8'($urandom);
            b  = (i == 0) ? 8'h03 : 8'($urandom);
            fb = (i == 0) ? 8'h00 : {4'($urandom), 4'($urandom_range(0, 4))};
            exp = alu_fn(a, b, fb[3:0]);
            wb = obs_wr.size(); ab = obs_alu.size(); tb = obs_tx.size(); vb = busy_viol;
            send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(fb);
            n_chk++;
            if (CLK_GATE_EN !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_gate: got %b want 1", CLK_GATE_EN);
            end
            wait_tx(tb, 2, 60, ok);
            settle(6);
            n_chk++;
            if (!ok || obs_wr.size() - wb !== 2 || obs_alu.size() - ab !== 1 || obs_tx.size() - tb !== 2) begin
                n_fail++;
                $display("FAIL alu_counts: got wr=%0d alu=%0d tx=%0d want 2 1 2",
                         obs_wr.size() - wb, obs_alu.size() - ab, obs_tx.size() - tb);
            end else begin
                n_chk++;
                if ({obs_wr[wb], obs_wr[wb+1]} !== {4'h0, a, 4'h1, b}) begin
                    n_fail++;
                    $display("FAIL alu_operands: got %h %h want %h %h", obs_wr[wb], obs_wr[wb+1], {4'h0, a}, {4'h1, b});
                end
                n_chk++;
                if (obs_alu[ab] !== fb[3:0]) begin
                    n_fail++;
                    $display("FAIL alu_fun: got %h want %h", obs_alu[ab], fb[3:0]);
                end
                n_chk++;
                if ({obs_tx[tb+1], obs_tx[tb]} !== exp) begin
                    n_fail++;
                    $display("FAIL alu_tx_bytes: got %h%h want %h", obs_tx[tb+1], obs_tx[tb], exp);
                end
                n_chk++;
                if (obs_tx_cyc[tb+1] - obs_tx_cyc[tb] < 2) begin
                    n_fail++;
                    $display("FAIL alu_tx_gap: got %0d cycles want >=2", obs_tx_cyc[tb+1] - obs_tx_cyc[tb]);
                end
            end
            n_chk++;
            if (busy_viol - vb !== 0) begin
                n_fail++;
                $display("FAIL alu_tx_while_busy: got %0d want 0", busy_viol - vb);
            end
            n_chk++;
            if (ALU_FUN !== fb[3:0]) begin
                n_fail++;
                $display("FAIL alu_fun_hold: got %h want %h", ALU_FUN, fb[3:0]);
            end
            ref_rf[0] = a;
            ref_rf[1] = b;
        end
    endtask

    task automatic test_busy_hold;
        logic [3:0] f;
        logic [15:0] exp;
        int tb, vb, wb, k;
        bit ok;
        f = 4'($urandom_range(0, 4));
        exp = alu_fn(ref_rf[0], ref_rf[1], f);
        tb = obs_tx.size(); wb = obs_wr.size(); vb = alu_vld_cnt;
        force_busy = 1'b1;
        send_byte(8'hDD); send_byte({4'h0, f});
        k = 0;
        while (alu_vld_cnt == vb && k < 30) begin
            @(negedge CLK);
            k++;
        end
        n_chk++;
        if (alu_vld_cnt == vb) begin
            n_fail++;
            $display("FAIL busy_alu_result: got no ALU_EN response want one");
        end
        settle(20);
        n_chk++;
        if (obs_tx.size() - tb !== 0) begin
            n_fail++;
            $display("FAIL busy_withheld: got %0d bytes want 0", obs_tx.size() - tb);
        end
        force_busy = 1'b0;
        wait_tx(tb, 2, 40, ok);
        settle(10);
        n_chk++;
        if (!ok || obs_tx.size() - tb !== 2 || obs_wr.size() - wb !== 0) begin
            n_fail++;
            $display("FAIL busy_counts: got tx=%0d wr=%0d want 2 0", obs_tx.size() - tb, obs_wr.size() - wb);
        end else begin
            n_chk++;
            if ({obs_tx[tb+1], obs_tx[tb]} !== exp) begin
                n_fail++;
                $display("FAIL busy_tx_bytes: got %h%h want %h", obs_tx[tb+1], obs_tx[tb], exp);
            end
        end
    endtask

    task automatic test_ignored;
        logic [7:0] a, b, d;
        logic [3:0] f;
        int wb, ab, tb, rb;
        bit ok;
        wb = obs_wr.size(); ab = obs_alu.size(); tb = obs_tx.size(); rb = obs_rd.size();
        send_byte(8'h55);
        settle(3);
        n_chk++;
        if ({CLK_GATE_EN, 32'(obs_wr.size() + obs_alu.size() + obs_tx.size() + obs_rd.size() - wb - ab - tb - rb)} !== 33'd0) begin
            n_fail++;
            $display("FAIL ign_idle_byte: got gate=%b events=%0d want 0 0", CLK_GATE_EN,
                     obs_wr.size() + obs_alu.size() + obs_tx.size() + obs_rd.size() - wb - ab - tb - rb);
        end
        a = 8'($urandom); b = 8'($urandom); f = 4'($urandom_range(0, 4));
        alu_lat = 12;
        send_byte(8'hCC); send_byte(a); send_byte(b); send_byte({4'h0, f});
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h11);
        wait_tx(tb, 2, 60, ok);
        settle(8);
        alu_lat = 3;
        n_chk++;
        if (!ok || obs_wr.size() - wb !== 2 || obs_alu.size() - ab !== 1 || obs_tx.size() - tb !== 2 || obs_rd.size() - rb !== 0) begin
            n_fail++;
            $display("FAIL ign_wait_counts: got wr=%0d alu=%0d tx=%0d rd=%0d want 2 1 2 0",
                     obs_wr.size() - wb, obs_alu.size() - ab, obs_tx.size() - tb, obs_rd.size() - rb);
        end else begin
            n_chk++;
            if ({obs_tx[tb+1], obs_tx[tb]} !== alu_fn(a, b, f)) begin
                n_fail++;
                $display("FAIL ign_tx_bytes: got %h%h want %h", obs_tx[tb+1], obs_tx[tb], alu_fn(a, b, f));
            end
        end
        ref_rf[0] = a; ref_rf[1] = b;
        wb = obs_wr.size();
        d = 8'($urandom);
        send_byte(8'hAA); send_byte(8'h07); send_byte(d);
        settle(4);
        n_chk++;
        if (obs_wr.size() - wb !== 1 || obs_wr[obs_wr.size()-1] !== {4'h7, d}) begin
            n_fail++;
            $display("FAIL ign_next_frame: got %0d writes last=%h want 1 %h", obs_wr.size() - wb, obs_wr[obs_wr.size()-1], {4'h7, d});
        end
        ref_rf[7] = d;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int wb, ab;
        wb = obs_wr.size(); ab = obs_alu.size();
        send_byte(8'hCC); send_byte(8'h0A);
        n_chk++;
        if (CLK_GATE_EN !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_gate_before: got %b want 1", CLK_GATE_EN);
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_chk++;
        if ({RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CLK_GATE_EN, RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h want 0",
                     {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CLK_GATE_EN, RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA});
        end
        @(negedge CLK);
        RST = 1'b0;
        ref_rf[0] = 8'h0A;
        settle(2);
        d = 8'($urandom);
        send_byte(8'hAA); send_byte(8'h09); send_byte(d);
        settle(6);
        n_chk++;
        if (obs_wr.size() - wb !== 2 || obs_wr[obs_wr.size()-1] !== {4'h9, d} || obs_alu.size() - ab !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_recover: got wr=%0d last=%h alu=%0d want 2 %h 0",
                     obs_wr.size() - wb, obs_wr[obs_wr.size()-1], obs_alu.size() - ab, {4'h9, d});
        end
        ref_rf[9] = d;
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout;
        int wb, ab;
        wb = obs_wr.size(); ab = obs_alu.size();
        send_byte(8'hCC); send_byte(8'h0A);
        ref_rf[0] = 8'h0A;
        settle(TMO - 20);
        n_chk++;
        if (CLK_GATE_EN !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: got gate=%b want 1", CLK_GATE_EN);
        end
        settle(30);
        n_chk++;
        if (CLK_GATE_EN !== 1'b0 || obs_alu.size() - ab !== 0 || obs_wr.size() - wb !== 1) begin
            n_fail++;
            $display("FAIL tmo_abort: got gate=%b alu=%0d wr=%0d want 0 0 1", CLK_GATE_EN, obs_alu.size() - ab, obs_wr.size() - wb);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_write(5);
        test_read(4);
        test_alu_op(6);
        test_busy_hold;
        test_read(2);
        test_ignored;
        test_reset_mid;
`ifdef CMD_TIMEOUT_EN
        test_timeout;
        test_write(1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
